// File: rtl/zigzag_input_buffer.sv
// -----------------------------------------------------------------------------
// zigzag_input_buffer
//
// Elastic input stage in front of the zigzag decryptor. Incoming bytes are
// queued in a FIFO. They are replayed to the decryptor one per cycle, and
// only while the decryptor is not busy emitting a previously completed message.
// This lets the source send messages back-to-back.
//
// Ports:
//   clk          system clock, everything on the rising edge
//   rst          synchronous active-high reset
//   data_i       incoming byte from the source
//   valid_i      data_i qualifier; a byte is taken when valid_i && ready_o
//   ready_o      FIFO not full (combinational from the FIFO count)
//   data_o       byte forwarded to the decryptor
//   valid_o      one-cycle qualifier per forwarded byte
//   busy_i       decryptor busy flag
//   msg_count_o  complete messages (tokens) held in the FIFO, saturating at 63
//   overflow_o   sticky error: byte dropped (FIFO full or message too long)
// -----------------------------------------------------------------------------
module zigzag_input_buffer #(
    parameter int                   D_WIDTH                = 8,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter int                   FIFO_DEPTH             = 64,
    parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 'hFA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [D_WIDTH-1:0] data_o,
    output logic               valid_o,
    input  logic               busy_i,
    output logic [5:0]         msg_count_o,
    output logic               overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(MAX_NOF_CHARS + 1);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_NOF_CHARS);

    typedef enum logic [1:0] {
        FORWARD   = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Payload storage (read through the data_o register) plus a one-bit
    // token tag per entry. The tag is read combinationally so the FSM can
    // decide at the pop edge whether the byte leaving is the token, without
    // needing an asynchronous read of the wide payload array.
    logic [D_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic               tok_q [FIFO_DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [LW-1:0]      len_q, len_d;
    logic [5:0]         msg_count_q, msg_count_d;
    logic               overflow_q, overflow_d;

    state_t             state_q;
    logic [1:0]         timer_q;
    logic [D_WIDTH-1:0] data_q;
    logic               valid_q;

    logic in_is_tok;
    logic len_full;
    logic push;
    logic pop;
    logic head_tok;

    // ---------------------------------------------------------------- write side
    assign ready_o   = (count_q != FULL_CNT);
    assign in_is_tok = (data_i == START_DECRYPTION_TOKEN);
    assign len_full  = (len_q == MAX_LEN);
    // A token is always accepted when there is room; a plain byte only while
    // the current message is still within the decryptor's character limit.
    assign push      = valid_i && ready_o && (in_is_tok || !len_full);

    // ----------------------------------------------------------------- read side
    assign pop      = (state_q == FORWARD) && (count_q != '0) && !busy_i;
    assign head_tok = tok_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        len_d       = len_q;
        msg_count_d = msg_count_q;
        overflow_d  = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            len_d    = in_is_tok ? '0 : len_q + LW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // Simultaneous push and pop leaves the count unchanged.
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (valid_i && !push) begin
            overflow_d = 1'b1;
        end

        if ((push && in_is_tok) && !(pop && head_tok)) begin
            if (msg_count_q != 6'd63) begin
                msg_count_d = msg_count_q + 6'd1;
            end
        end else if ((pop && head_tok) && !(push && in_is_tok)) begin
            if (msg_count_q != 6'd0) begin
                msg_count_d = msg_count_q - 6'd1;
            end
        end
    end

    // Storage write port; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
            tok_q[wr_ptr_q] <= in_is_tok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            len_q       <= '0;
            msg_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            msg_count_q <= msg_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Replay FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FORWARD;
            timer_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FORWARD: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        valid_q <= 1'b1;
                        if (head_tok) begin
                            state_q <= WAIT_BUSY;
                            timer_q <= '0;
                        end
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                WAIT_BUSY: begin
                    valid_q <= 1'b0;
                    if (busy_i) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        // Decryptor may never raise busy (empty message);
                        // give up waiting once the timer reaches 2.
                        timer_q <= timer_q + 2'd1;
                        if (timer_q == 2'd1) begin
                            state_q <= FORWARD;
                        end
                    end
                end
                WAIT_DONE: begin
                    valid_q <= 1'b0;
                    if (!busy_i) begin
                        state_q <= FORWARD;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= FORWARD;
                end
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign msg_count_o = msg_count_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_zigzag_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_zigzag_input_buffer
//
// Directed bench for zigzag_input_buffer. Inputs are driven 1 ns after each
// rising edge and outputs are checked at that same point, so every check sees
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_zigzag_input_buffer;

    localparam logic [7:0] TOK = 8'hFA;

    logic       clk;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_i;
    logic [5:0] msg_count_o;
    logic       overflow_o;

    int total = 0;
    int bad   = 0;

    zigzag_input_buffer #(
        .D_WIDTH                (8),
        .MAX_NOF_CHARS          (50),
        .FIFO_DEPTH             (64),
        .START_DECRYPTION_TOKEN (8'hFA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy_i      (busy_i),
        .msg_count_o (msg_count_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, check the forwarded byte.
    task automatic step(input logic v, input logic [7:0] d, input logic b,
                        input logic ev, input logic [7:0] ed, input string tag);
        valid_i = v;
        data_i  = d;
        busy_i  = b;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 32'(valid_o), 32'(ev));
        if (ev) chk({tag, "_data"}, 32'(data_o), 32'(ed));
        $display("step %s: valid_o=%0d data_o=%02h msg=%0d ovf=%0d rdy=%0d",
                 tag, valid_o, data_o, msg_count_o, overflow_o, ready_o);
    endtask

    function automatic logic [7:0] full_byte(input int i);
        return (i == 39) ? TOK : 8'(8'h10 + i);
    endfunction

    initial begin
        // ---------------------------------------------------------- reset
        rst = 1'b1; valid_i = 1'b1; data_i = 8'h41; busy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_msg",   32'(msg_count_o), 0);
        chk("rst_ovf",   32'(overflow_o), 0);
        chk("rst_data",  32'(data_o), 0);
        rst = 1'b0;
        step(0, 8'h00, 0, 0, 8'h00, "rst_nopush");

        // ------------------------------------------------- single message
        step(1, 8'h41, 0, 0, 8'h00, "s1_lat");
        step(1, 8'h42, 0, 1, 8'h41, "s1_b0");
        step(1, 8'h43, 0, 1, 8'h42, "s1_b1");
        step(1, TOK,   0, 1, 8'h43, "s1_b2");
        chk("s1_msg1", 32'(msg_count_o), 1);
        step(0, 8'h00, 0, 1, TOK,   "s1_tok");
        chk("s1_msg0", 32'(msg_count_o), 0);
        step(0, 8'h00, 0, 0, 8'h00, "s1_wb0");
        step(0, 8'h00, 0, 0, 8'h00, "s1_wb1");

        // ---------------------------------------- back-to-back messages
        step(1, 8'h41, 0, 0, 8'h00, "b2b_p1");
        step(1, 8'h42, 0, 1, 8'h41, "b2b_p2");
        step(1, TOK,   0, 1, 8'h42, "b2b_p3");
        step(1, 8'h51, 0, 1, TOK,   "b2b_p4");
        step(1, 8'h52, 0, 0, 8'h00, "b2b_p5");
        step(1, 8'h53, 1, 0, 8'h00, "b2b_p6");
        step(1, TOK,   1, 0, 8'h00, "b2b_p7");
        chk("b2b_msg1", 32'(msg_count_o), 1);
        step(0, 8'h00, 1, 0, 8'h00, "b2b_p8");
        step(0, 8'h00, 0, 0, 8'h00, "b2b_p9");
        step(0, 8'h00, 0, 1, 8'h51, "b2b_p10");
        step(0, 8'h00, 0, 1, 8'h52, "b2b_p11");
        step(0, 8'h00, 0, 1, 8'h53, "b2b_p12");
        step(0, 8'h00, 0, 1, TOK,   "b2b_p13");
        chk("b2b_msg0", 32'(msg_count_o), 0);
        step(0, 8'h00, 0, 0, 8'h00, "b2b_p14");
        step(0, 8'h00, 0, 0, 8'h00, "b2b_p15");

        // ------------------------------------------------- empty message
        step(1, TOK,   0, 0, 8'h00, "em_q1");
        chk("em_msg1", 32'(msg_count_o), 1);
        step(1, 8'h61, 0, 1, TOK,   "em_q2");
        step(1, 8'h62, 0, 0, 8'h00, "em_q3");
        step(1, TOK,   0, 0, 8'h00, "em_q4");
        step(0, 8'h00, 0, 1, 8'h61, "em_q5");
        step(0, 8'h00, 0, 1, 8'h62, "em_q6");
        step(0, 8'h00, 0, 1, TOK,   "em_q7");
        step(0, 8'h00, 0, 0, 8'h00, "em_q8");
        step(0, 8'h00, 0, 0, 8'h00, "em_q9");

        // ---------------------------------------------------- full FIFO
        step(1, TOK,   0, 0, 8'h00, "full_r1");
        step(0, 8'h00, 0, 1, TOK,   "full_r2");
        for (int i = 0; i < 70; i++) begin
            step(1, full_byte(i), 1, 0, 8'h00, $sformatf("full_push%0d", i));
            if (i == 62) chk("full_rdy62", 32'(ready_o), 1);
            if (i == 63) begin
                chk("full_rdy63", 32'(ready_o), 0);
                chk("full_ovf63", 32'(overflow_o), 0);
            end
            if (i == 64) chk("full_ovf64", 32'(overflow_o), 1);
        end
        chk("full_msg", 32'(msg_count_o), 1);
        step(0, 8'h00, 0, 0, 8'h00, "full_s0");
        for (int i = 0; i < 40; i++) begin
            step(0, 8'h00, 0, 1, full_byte(i), $sformatf("full_pop%0d", i));
        end
        chk("full_rdy_after", 32'(ready_o), 1);
        step(0, 8'h00, 0, 0, 8'h00, "full_gap0");
        step(0, 8'h00, 0, 0, 8'h00, "full_gap1");
        for (int i = 40; i < 64; i++) begin
            step(0, 8'h00, 0, 1, full_byte(i), $sformatf("full_pop%0d", i));
        end
        step(0, 8'h00, 0, 0, 8'h00, "full_empty");
        chk("full_msg0", 32'(msg_count_o), 0);
        chk("full_ovf_sticky", 32'(overflow_o), 1);

        // ---------------------------------------- reset mid-message
        step(1, 8'h71, 1, 0, 8'h00, "mr_p0");
        step(1, 8'h72, 1, 0, 8'h00, "mr_p1");
        step(1, TOK,   1, 0, 8'h00, "mr_p2");
        rst = 1'b1;
        step(0, 8'h00, 0, 0, 8'h00, "mr_rst");
        rst = 1'b0;
        chk("mr_ovf", 32'(overflow_o), 0);
        chk("mr_msg", 32'(msg_count_o), 0);
        step(0, 8'h00, 0, 0, 8'h00, "mr_idle0");
        step(0, 8'h00, 0, 0, 8'h00, "mr_idle1");
        step(0, 8'h00, 0, 0, 8'h00, "mr_idle2");

        // ------------------------------------------------- length limit
        for (int i = 0; i < 51; i++) begin
            step(1, 8'(8'h20 + i), 1, 0, 8'h00, $sformatf("len_push%0d", i));
            if (i == 49) chk("len_ovf49", 32'(overflow_o), 0);
            if (i == 50) chk("len_ovf50", 32'(overflow_o), 1);
        end
        step(1, TOK, 1, 0, 8'h00, "len_tok");
        chk("len_msg", 32'(msg_count_o), 1);
        for (int i = 0; i < 50; i++) begin
            step(0, 8'h00, 0, 1, 8'(8'h20 + i), $sformatf("len_pop%0d", i));
        end
        step(0, 8'h00, 0, 1, TOK,   "len_pop_tok");
        step(0, 8'h00, 0, 0, 8'h00, "len_after0");
        step(0, 8'h00, 0, 0, 8'h00, "len_after1");
        step(0, 8'h00, 0, 0, 8'h00, "len_after2");
        chk("len_msg0", 32'(msg_count_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
